gpu_pixel_arbiter: RTL and testbench

Shares the single framebuffer pixel-write path between the line-draw engine and the fill engine. Each engine presents one pixel (x, y, r, g, b) under a req/ack handshake; the arbiter picks one per accept cycle, registers it into a one-entry output stage, and holds it until the framebuffer writer signals ready. Line pixels have priority. A burst limit stops either engine from starving the other. `line_active`/`fill_active` report the current owner for downstream status logic.

---
 rtl/gpu_pixel_arbiter.sv | 134 +++++++++++++
 tb/tb_gpu_pixel_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_pixel_arbiter.sv
// Arbitrates the framebuffer pixel-write path between the line and fill engines.
// Line has priority, and a burst limit keeps either engine from starving the other.
module gpu_pixel_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 10,
  parameter int CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    line_req,
  input  logic [WIDTH_BITS-1:0]   x_line_i,
  input  logic [HEIGHT_BITS-1:0]  y_line_i,
  input  logic [CHANNEL_BITS-1:0] r_line_i,
  input  logic [CHANNEL_BITS-1:0] g_line_i,
  input  logic [CHANNEL_BITS-1:0] b_line_i,
  input  logic                    fill_req,
  input  logic [WIDTH_BITS-1:0]   x_fill_i,
  input  logic [HEIGHT_BITS-1:0]  y_fill_i,
  input  logic [CHANNEL_BITS-1:0] r_fill_i,
  input  logic [CHANNEL_BITS-1:0] g_fill_i,
  input  logic [CHANNEL_BITS-1:0] b_fill_i,
  input  logic                    out_ready,
  output logic                    line_ack,
  output logic                    fill_ack,
  output logic                    pix_valid,
  output logic [WIDTH_BITS-1:0]   x_o,
  output logic [HEIGHT_BITS-1:0]  y_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    line_active,
  output logic                    fill_active
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LINE = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pix_valid;
  logic [WIDTH_BITS-1:0]   r_x;
  logic [HEIGHT_BITS-1:0]  r_y;
  logic [CHANNEL_BITS-1:0] r_r;
  logic [CHANNEL_BITS-1:0] r_g;
  logic [CHANNEL_BITS-1:0] r_b;

  logic                    w_accept;
  logic                    w_cnt_max;
  logic                    w_sel_line;
  logic                    w_sel_fill;
  logic [1:0]              w_next_owner;

  // The output stage frees up either when empty or when its pixel is consumed now.
  assign w_accept  = !r_pix_valid || out_ready;
  assign w_cnt_max = (r_cnt == CNT_MAX);

  // Selection uses only req/state/cnt/accept so data never reaches the acks.
  always_comb begin
    w_sel_line = 1'b0;
    w_sel_fill = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_LINE: begin
          if (line_req && !(fill_req && w_cnt_max)) w_sel_line = 1'b1;
          else if (fill_req)                        w_sel_fill = 1'b1;
        end
        S_FILL: begin
          if (fill_req && !(line_req && w_cnt_max)) w_sel_fill = 1'b1;
          else if (line_req)                        w_sel_line = 1'b1;
        end
        default: begin
          if (line_req)      w_sel_line = 1'b1;
          else if (fill_req) w_sel_fill = 1'b1;
        end
      endcase
    end
  end

  assign w_next_owner = w_sel_line ? S_LINE : S_FILL;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pix_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
    end else if (w_accept) begin
      if (w_sel_line || w_sel_fill) begin
        r_pix_valid <= 1'b1;
        r_state     <= w_next_owner;
        if (r_state != w_next_owner) r_cnt <= CNT_W'(1);
        else if (!w_cnt_max)         r_cnt <= r_cnt + CNT_W'(1);
        if (w_sel_line) begin
          r_x <= x_line_i;
          r_y <= y_line_i;
          r_r <= r_line_i;
          r_g <= g_line_i;
          r_b <= b_line_i;
        end else begin
          r_x <= x_fill_i;
          r_y <= y_fill_i;
          r_r <= r_fill_i;
          r_g <= g_fill_i;
          r_b <= b_fill_i;
        end
      end else begin
        r_pix_valid <= 1'b0;
        r_state     <= S_IDLE;
        r_cnt       <= '0;
      end
    end
  end

  assign line_ack    = w_sel_line;
  assign fill_ack    = w_sel_fill;
  assign pix_valid   = r_pix_valid;
  assign x_o         = r_x;
  assign y_o         = r_y;
  assign r_o         = r_r;
  assign g_o         = r_g;
  assign b_o         = r_b;
  assign line_active = (r_state == S_LINE);
  assign fill_active = (r_state == S_FILL);

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Directed bench for gpu_pixel_arbiter: one instance with MAX_BURST=4 and one with
// MAX_BURST=1, both driven by the same stimulus.
module tb_gpu_pixel_arbiter;

  localparam int WB = 10;
  localparam int HB = 10;
  localparam int CB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst, line_req, fill_req, out_ready;
  logic [WB-1:0] x_line_i, x_fill_i;
  logic [HB-1:0] y_line_i, y_fill_i;
  logic [CB-1:0] r_line_i, g_line_i, b_line_i, r_fill_i, g_fill_i, b_fill_i;

  logic          a_line_ack, a_fill_ack, a_pix_valid, a_line_active, a_fill_active;
  logic [WB-1:0] a_x_o;
  logic [HB-1:0] a_y_o;
  logic [CB-1:0] a_r_o, a_g_o, a_b_o;
  logic          b_line_ack, b_fill_ack, b_pix_valid, b_line_active, b_fill_active;
  logic [WB-1:0] b_x_o;
  logic [HB-1:0] b_y_o;
  logic [CB-1:0] b_r_o, b_g_o, b_b_o;

  gpu_pixel_arbiter #(.MAX_BURST(4), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) u_dut4 (
    .clk(clk), .n_rst(n_rst),
    .line_req(line_req), .x_line_i(x_line_i), .y_line_i(y_line_i),
    .r_line_i(r_line_i), .g_line_i(g_line_i), .b_line_i(b_line_i),
    .fill_req(fill_req), .x_fill_i(x_fill_i), .y_fill_i(y_fill_i),
    .r_fill_i(r_fill_i), .g_fill_i(g_fill_i), .b_fill_i(b_fill_i),
    .out_ready(out_ready), .line_ack(a_line_ack), .fill_ack(a_fill_ack),
    .pix_valid(a_pix_valid), .x_o(a_x_o), .y_o(a_y_o), .r_o(a_r_o), .g_o(a_g_o), .b_o(a_b_o),
    .line_active(a_line_active), .fill_active(a_fill_active)
  );

  gpu_pixel_arbiter #(.MAX_BURST(1), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) u_dut1 (
    .clk(clk), .n_rst(n_rst),
    .line_req(line_req), .x_line_i(x_line_i), .y_line_i(y_line_i),
    .r_line_i(r_line_i), .g_line_i(g_line_i), .b_line_i(b_line_i),
    .fill_req(fill_req), .x_fill_i(x_fill_i), .y_fill_i(y_fill_i),
    .r_fill_i(r_fill_i), .g_fill_i(g_fill_i), .b_fill_i(b_fill_i),
    .out_ready(out_ready), .line_ack(b_line_ack), .fill_ack(b_fill_ack),
    .pix_valid(b_pix_valid), .x_o(b_x_o), .y_o(b_y_o), .r_o(b_r_o), .g_o(b_g_o), .b_o(b_b_o),
    .line_active(b_line_active), .fill_active(b_fill_active)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Line pixel k: x=k, y=k+16, r=k+32; fill pixel k: x=k+100, y=k+200, r=k+64.
  task automatic set_line(input int k);
    x_line_i = WB'(k);
    y_line_i = HB'(k + 16);
    r_line_i = CB'(k + 32);
    g_line_i = CB'(k + 48);
    b_line_i = CB'(k + 80);
  endtask

  task automatic set_fill(input int k);
    x_fill_i = WB'(k + 100);
    y_fill_i = HB'(k + 200);
    r_fill_i = CB'(k + 64);
    g_fill_i = CB'(k + 96);
    b_fill_i = CB'(k + 128);
  endtask

  // Advance to just after the next rising edge; inputs are then changed there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lc;
    logic exp_l;
    n_rst = 1'b0; line_req = 1'b0; fill_req = 1'b0; out_ready = 1'b1;
    set_line(0); set_fill(0);
    tick(); tick();
    chk("rst_valid4", a_pix_valid, 0);
    chk("rst_x4", a_x_o, 0);
    chk("rst_lact4", a_line_active, 0);
    chk("rst_fact4", a_fill_active, 0);
    chk("rst_valid1", b_pix_valid, 0);
    n_rst = 1'b1;
    tick();

    // Line engine alone: five pixels back to back.
    line_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_line(i);
      #1;
      chk("lo_lack", a_line_ack, 1);
      chk("lo_fack", a_fill_ack, 0);
      tick();
      chk("lo_valid", a_pix_valid, 1);
      chk("lo_x", a_x_o, i);
      chk("lo_y", a_y_o, i + 16);
      chk("lo_lact", a_line_active, 1);
    end
    line_req = 1'b0;
    #1;
    chk("lo_noack", a_line_ack, 0);
    tick();
    chk("lo_idle_valid", a_pix_valid, 0);
    chk("lo_idle_lact", a_line_active, 0);
    chk("lo_idle_fact", a_fill_active, 0);
    chk("lo_hold_x", a_x_o, 4);

    // Both requesting from IDLE: line first, then blocks of four.
    set_line(7); set_fill(9);
    line_req = 1'b1; fill_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_l = ((k / 4) % 2) == 0;
      #1;
      chk(k == 0 ? "prio_lack" : "ct_lack", a_line_ack, exp_l);
      chk(k == 0 ? "prio_fack" : "ct_fack", a_fill_ack, !exp_l);
      tick();
      chk("ct_lact", a_line_active, exp_l);
      chk("ct_fact", a_fill_active, !exp_l);
      chk("ct_x", a_x_o, exp_l ? 7 : 109);
    end
    line_req = 1'b0; fill_req = 1'b0;
    tick();

    // Line drops mid-burst: fill takes over on the very next accept.
    line_req = 1'b1; set_line(3);
    tick(); tick();
    line_req = 1'b0; fill_req = 1'b1; set_fill(5);
    #1;
    chk("drop_fack", a_fill_ack, 1);
    chk("drop_lack", a_line_ack, 0);
    tick();
    chk("drop_fact", a_fill_active, 1);
    chk("drop_x", a_x_o, 105);
    fill_req = 1'b0;
    tick();

    // Backpressure in the middle of a line burst; fill is also waiting.
    lc = 0;
    set_line(10); set_fill(50);
    line_req = 1'b1; fill_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_pre_lack", a_line_ack, 1);
      tick();
      chk("bp_pre_x", a_x_o, 10 + lc);
      lc++;
      set_line(10 + lc);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_lack", a_line_ack, 0);
      chk("bp_fack", a_fill_ack, 0);
      tick();
      chk("bp_x", a_x_o, 11);
      chk("bp_valid", a_pix_valid, 1);
      chk("bp_lact", a_line_active, 1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_post_lack", a_line_ack, 1);
      tick();
      chk("bp_post_x", a_x_o, 10 + lc);
      lc++;
      set_line(10 + lc);
    end
    #1;
    chk("bp_sw_fack", a_fill_ack, 1);
    chk("bp_sw_lack", a_line_ack, 0);
    tick();
    chk("bp_sw_x", a_x_o, 150);
    chk("bp_sw_fact", a_fill_active, 1);
    line_req = 1'b0; fill_req = 1'b0;
    tick();

    // Reset in the middle of a fill burst (FILL, cnt=3, pixel pending).
    fill_req = 1'b1; set_fill(20);
    tick(); tick(); tick();
    chk("mr_pre_fact", a_fill_active, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mr_valid", a_pix_valid, 0);
    chk("mr_x", a_x_o, 0);
    chk("mr_r", a_r_o, 0);
    chk("mr_fact", a_fill_active, 0);
    chk("mr_lact", a_line_active, 0);
    fill_req = 1'b0;
    tick();
    n_rst = 1'b1;
    line_req = 1'b1; fill_req = 1'b1; set_line(3); set_fill(20);
    for (int k = 0; k < 5; k++) begin
      exp_l = (k < 4);
      #1;
      chk("mr_lack", a_line_ack, exp_l);
      chk("mr_fack", a_fill_ack, !exp_l);
      tick();
      chk("mr_x_after", a_x_o, exp_l ? 3 : 120);
    end
    line_req = 1'b0; fill_req = 1'b0;
    tick();

    // MAX_BURST=1: strict alternation.
    set_line(1); set_fill(2);
    line_req = 1'b1; fill_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_l = (k % 2) == 0;
      #1;
      chk("mb1_lack", b_line_ack, exp_l);
      chk("mb1_fack", b_fill_ack, !exp_l);
      tick();
      chk("mb1_lact", b_line_active, exp_l);
      chk("mb1_x", b_x_o, exp_l ? 1 : 102);
    end
    line_req = 1'b0; fill_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
